timer_cmd_tx: RTL and testbench

- Initiator side of the serial delay-timer protocol.
- Accepts a 4-bit delay command over a valid/ready interface and serialises it onto a single-bit line, MSB first: start pattern 1101, then the 4 delay bits.
- Waits for the remote timer's done, then pulses ack and reports a completion or timeout response.
- Sits between the command/control logic and the timer's data/ack/done pins.

---
 rtl/timer_cmd_tx_pkg.sv | 20 ++
 rtl/timer_cmd_tx_if.sv | 32 +++
 rtl/timer_cmd_tx_serializer.sv | 50 +++++
 rtl/timer_cmd_tx.sv | 174 +++++++++++++++++
 tb/tb_timer_cmd_tx.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_cmd_tx_pkg.sv
// timer_proto_pkg
// Definitions shared by both ends of the serial delay-timer protocol: the
// initiator FSM state type, the default start pattern and delay width, and the
// number of clock ticks the remote timer counts per delay unit.
package timer_proto_pkg;

  localparam logic [3:0] PATTERN_DEFAULT = 4'b1101;
  localparam int         DELAY_W_DEFAULT = 4;
  localparam int         TICKS_PER_UNIT  = 1000;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DELAY,
    WAIT_DONE,
    ACK,
    GAP
  } tx_state_t;

endpackage

// File: rtl/timer_cmd_tx_if.sv
// timer_cmd_tx_if
// Command and response bundle between the control logic (master) and the
// timer command transmitter (slave).
//   cmd_valid   master -> slave  command request
//   cmd_delay   master -> slave  delay value, sampled on handshake
//   cmd_ready   slave -> master  transmitter idle and able to accept
//   rsp_valid   slave -> master  1-cycle response pulse, no backpressure
//   rsp_timeout slave -> master  1 = the timer never reported done
//   rsp_cycles  slave -> master  cycles spent waiting for done
interface timer_cmd_tx_if #(
  parameter int DELAY_W = 4,
  parameter int CNT_W   = 16
) ();

  logic               cmd_valid;
  logic               cmd_ready;
  logic [DELAY_W-1:0] cmd_delay;
  logic               rsp_valid;
  logic               rsp_timeout;
  logic [CNT_W-1:0]   rsp_cycles;

  modport master (
    output cmd_valid, cmd_delay,
    input  cmd_ready, rsp_valid, rsp_timeout, rsp_cycles
  );

  modport slave (
    input  cmd_valid, cmd_delay,
    output cmd_ready, rsp_valid, rsp_timeout, rsp_cycles
  );

endinterface

// File: rtl/timer_cmd_tx_serializer.sv
// timer_cmd_serializer
// Loads one command frame ({start pattern, delay}) and shifts it out MSB first,
// one bit per clock. The line bit is taken straight from the top flop of the
// shift register, and zeros shift in behind the frame, so the line returns to
// 0 by itself once the frame is finished and is 0 immediately on reset.
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   load      capture load_word; its MSB is on the line the next cycle
//   load_word frame to send, MSB first
//   data      serial line (flop output)
//   last_bit  high while the final frame bit is on the line
module timer_cmd_serializer #(
  parameter int FRAME_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_word,
  output logic               data,
  output logic               last_bit
);

  localparam int IDX_W = $clog2(FRAME_W);

  logic [FRAME_W-1:0] shreg;
  logic [IDX_W-1:0]   idx;
  logic               active;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg  <= '0;
      idx    <= '0;
      active <= 1'b0;
    end else if (load) begin
      shreg  <= load_word;
      idx    <= '0;
      active <= 1'b1;
    end else if (active) begin
      shreg <= {shreg[FRAME_W-2:0], 1'b0};
      idx   <= idx + 1'b1;
      if (last_bit) begin
        active <= 1'b0;
      end
    end
  end

  assign data     = shreg[FRAME_W-1];
  assign last_bit = active && (idx == IDX_W'(FRAME_W - 1));

endmodule

// File: rtl/timer_cmd_tx.sv
// timer_cmd_tx
// Initiator side of the serial delay-timer protocol. Accepts a delay command,
// sends the start pattern and the delay bits MSB first on 'data', waits for
// the remote timer's done, pulses ack, and reports completion or timeout.
// After each command the line is held at 0 for GAP_CYC cycles so the timer can
// re-arm its pattern search.
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   cmd_if      command/response bundle (slave side)
//   data        serial line to the timer (registered)
//   timer_done  timer's done level, held until ack
//   ack         registered 1-cycle acknowledge to the timer
//   busy        high in every state except IDLE
module timer_cmd_tx
  import timer_proto_pkg::*;
#(
  parameter int         DELAY_W     = DELAY_W_DEFAULT,
  parameter logic [3:0] PATTERN     = PATTERN_DEFAULT,
  parameter int         TIMEOUT_CYC = 20000,
  parameter int         GAP_CYC     = 2,
  parameter int         CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  timer_cmd_tx_if.slave        cmd_if,
  output logic                 data,
  input  logic                 timer_done,
  output logic                 ack,
  output logic                 busy
);

  localparam int               FRAME_W      = 4 + DELAY_W;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       GAP_LAST     = 4'(GAP_CYC - 1);

  if (TIMEOUT_CYC >= 2**CNT_W) begin : g_bad_cnt_w
    $error("timer_cmd_tx: TIMEOUT_CYC must be below 2**CNT_W");
  end
  if (TIMEOUT_CYC <= 16 * TICKS_PER_UNIT) begin : g_bad_timeout
    $error("timer_cmd_tx: TIMEOUT_CYC must exceed the longest timer delay");
  end
  if (GAP_CYC < 1 || GAP_CYC > 15) begin : g_bad_gap
    $error("timer_cmd_tx: GAP_CYC must be in 1..15");
  end

  tx_state_t        state, state_nxt;
  logic [1:0]       bit_idx, bit_idx_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [3:0]       gap_cnt, gap_cnt_nxt;
  logic             ack_nxt;
  logic             rsp_valid_q, rsp_valid_nxt;
  logic             rsp_timeout_q, rsp_timeout_nxt;
  logic [CNT_W-1:0] rsp_cycles_q, rsp_cycles_nxt;
  logic             ser_load;
  logic             ser_last_bit;

  timer_cmd_serializer #(
    .FRAME_W (FRAME_W)
  ) u_serializer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (ser_load),
    .load_word ({PATTERN, cmd_if.cmd_delay}),
    .data      (data),
    .last_bit  (ser_last_bit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      bit_idx       <= '0;
      wait_cnt      <= '0;
      gap_cnt       <= '0;
      ack           <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_cycles_q  <= '0;
    end else begin
      state         <= state_nxt;
      bit_idx       <= bit_idx_nxt;
      wait_cnt      <= wait_cnt_nxt;
      gap_cnt       <= gap_cnt_nxt;
      ack           <= ack_nxt;
      rsp_valid_q   <= rsp_valid_nxt;
      rsp_timeout_q <= rsp_timeout_nxt;
      rsp_cycles_q  <= rsp_cycles_nxt;
    end
  end

  // ack and rsp_valid are computed one cycle early so that both come straight
  // from flops; the response fields hold their last value between pulses.
  // A done seen on the final wait cycle takes priority over the timeout.
  always_comb begin
    state_nxt       = state;
    bit_idx_nxt     = bit_idx;
    wait_cnt_nxt    = wait_cnt;
    gap_cnt_nxt     = gap_cnt;
    ack_nxt         = 1'b0;
    rsp_valid_nxt   = 1'b0;
    rsp_timeout_nxt = rsp_timeout_q;
    rsp_cycles_nxt  = rsp_cycles_q;
    ser_load        = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_if.cmd_valid) begin
          ser_load    = 1'b1;
          bit_idx_nxt = '0;
          state_nxt   = PREAMBLE;
        end
      end

      PREAMBLE: begin
        if (bit_idx == 2'd3) begin
          bit_idx_nxt = '0;
          state_nxt   = DELAY;
        end else begin
          bit_idx_nxt = bit_idx + 2'd1;
        end
      end

      DELAY: begin
        bit_idx_nxt = bit_idx + 2'd1;
        if (ser_last_bit) begin
          bit_idx_nxt  = '0;
          wait_cnt_nxt = '0;
          state_nxt    = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (timer_done) begin
          ack_nxt         = 1'b1;
          rsp_valid_nxt   = 1'b1;
          rsp_timeout_nxt = 1'b0;
          rsp_cycles_nxt  = wait_cnt;
          state_nxt       = ACK;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          rsp_valid_nxt   = 1'b1;
          rsp_timeout_nxt = 1'b1;
          rsp_cycles_nxt  = wait_cnt + 1'b1;
          gap_cnt_nxt     = '0;
          state_nxt       = GAP;
        end else if (wait_cnt != '1) begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end

      ACK: begin
        gap_cnt_nxt = '0;
        state_nxt   = GAP;
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 4'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy               = (state != IDLE);
  assign cmd_if.cmd_ready   = (state == IDLE);
  assign cmd_if.rsp_valid   = rsp_valid_q;
  assign cmd_if.rsp_timeout = rsp_timeout_q;
  assign cmd_if.rsp_cycles  = rsp_cycles_q;

endmodule

// File: tb/tb_timer_cmd_tx.sv
// tb_timer_cmd_tx
// Randomised bench for timer_cmd_tx. The driver issues commands and plays the
// remote timer (raising done a chosen number of cycles into the wait); each
// command's expectation goes into a queue. An independent monitor samples on
// the falling edge, pops an expectation at every accepted handshake and checks
// the serial frame, the response timing and fields, ack, and the gap before
// the transmitter becomes ready again.
module tb_timer_cmd_tx;
  import timer_proto_pkg::*;

  localparam int DELAY_W     = 4;
  localparam int CNT_W       = 16;
  localparam int TIMEOUT_CYC = 20000;
  localparam int GAP_CYC     = 2;
  localparam int FRAME_BITS  = 4 + DELAY_W;

  typedef struct {
    logic [3:0] delay;
    int         done_after;
  } cmd_t;

  logic clk        = 1'b0;
  logic reset_n    = 1'b1;
  logic timer_done = 1'b0;
  logic data;
  logic ack;
  logic busy;

  cmd_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  timer_cmd_tx_if #(.DELAY_W(DELAY_W), .CNT_W(CNT_W)) cmd_if ();

  timer_cmd_tx #(
    .DELAY_W     (DELAY_W),
    .PATTERN     (PATTERN_DEFAULT),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .GAP_CYC     (GAP_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_if     (cmd_if),
    .data       (data),
    .timer_done (timer_done),
    .ack        (ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Frame i-th bit on the line: start pattern first, then the delay, MSB first
  function automatic logic frameBit(input logic [3:0] delay, input int i);
    logic [3:0] pat;
    pat = PATTERN_DEFAULT;
    if (i < 4) return pat[3 - i];
    return delay[DELAY_W - 1 - (i - 4)];
  endfunction

  function automatic bit expTimeout(input int d);
    return d >= TIMEOUT_CYC;
  endfunction

  function automatic int expCycles(input int d);
    return expTimeout(d) ? TIMEOUT_CYC : d;
  endfunction

  // Cycles from the first wait cycle to the response pulse
  function automatic int expRspLatency(input int d);
    return expTimeout(d) ? TIMEOUT_CYC : d + 1;
  endfunction

  // Cycles after the response pulse until the transmitter is idle again
  function automatic int expIdleAfterRsp(input int d);
    return expTimeout(d) ? GAP_CYC : GAP_CYC + 1;
  endfunction

  // Issue one command; d = wait cycles before done is raised (>= TIMEOUT_CYC
  // means never). Returns in the response cycle. hold_after keeps cmd_valid
  // high for the rest of the command.
  task automatic applyStimulus(input logic [3:0] delay, input int d, input bit hold_after);
    cmd_t c;
    int   n;
    c.delay      = delay;
    c.done_after = d;
    exp_q.push_back(c);
    cmd_if.cmd_delay = delay;
    cmd_if.cmd_valid = 1'b1;
    n = 0;
    while (cmd_if.cmd_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (cmd_if.cmd_ready !== 1'b1) begin
      checkOutput("accept_wait", cmd_if.cmd_ready, 1);
      cmd_if.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_if.cmd_valid = hold_after;
    repeat (FRAME_BITS) begin
      @(posedge clk); #1;
    end
    if (d < TIMEOUT_CYC) begin
      repeat (d) begin
        @(posedge clk); #1;
      end
      timer_done = 1'b1;
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (ack !== 1'b1 && n < 4);
      if (ack !== 1'b1) checkOutput("ack_wait", ack, 1);
      timer_done = 1'b0;
    end else begin
      n = 0;
      while (cmd_if.rsp_valid !== 1'b1 && n < TIMEOUT_CYC + 10) begin
        @(posedge clk); #1;
        n++;
      end
      if (cmd_if.rsp_valid !== 1'b1) checkOutput("rsp_wait", cmd_if.rsp_valid, 1);
    end
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    int               phase;
    int               bitn;
    int               wcnt;
    int               k;
    cmd_t             cur;
    logic [CNT_W-1:0] held_cycles;
    phase       = 0;
    bitn        = 0;
    wcnt        = 0;
    k           = 0;
    held_cycles = '0;
    cur.delay      = '0;
    cur.done_after = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        phase       = 0;
        held_cycles = '0;
        checkOutput("reset_data", data, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_ack", ack, 0);
        checkOutput("reset_rsp_valid", cmd_if.rsp_valid, 0);
        checkOutput("reset_rsp_timeout", cmd_if.rsp_timeout, 0);
        checkOutput("reset_rsp_cycles", cmd_if.rsp_cycles, 0);
        checkOutput("reset_ready", cmd_if.cmd_ready, 1);
      end else begin
        if (phase == 3) begin
          k++;
          checkOutput("gap_data", data, 0);
          checkOutput("gap_ack", ack, 0);
          checkOutput("gap_rsp_valid", cmd_if.rsp_valid, 0);
          checkOutput("gap_rsp_hold", cmd_if.rsp_cycles, held_cycles);
          if (k == expIdleAfterRsp(cur.done_after)) begin
            checkOutput("ready_return", cmd_if.cmd_ready, 1);
            phase = 0;
          end else begin
            checkOutput("gap_busy", busy, 1);
            checkOutput("gap_ready", cmd_if.cmd_ready, 0);
          end
        end
        if (phase == 0) begin
          checkOutput("idle_data", data, 0);
          checkOutput("idle_busy", busy, 0);
          checkOutput("idle_ready", cmd_if.cmd_ready, 1);
          checkOutput("idle_ack", ack, 0);
          checkOutput("idle_rsp_valid", cmd_if.rsp_valid, 0);
          checkOutput("idle_rsp_hold", cmd_if.rsp_cycles, held_cycles);
          if (cmd_if.cmd_valid === 1'b1) begin
            checkOutput("accept_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              cur = exp_q.pop_front();
              checkOutput("accept_delay", cmd_if.cmd_delay, cur.delay);
              phase = 1;
              bitn  = 0;
            end
          end
        end else if (phase == 1) begin
          checkOutput($sformatf("frame_bit%0d", bitn), data, frameBit(cur.delay, bitn));
          checkOutput("frame_busy", busy, 1);
          checkOutput("frame_ready", cmd_if.cmd_ready, 0);
          checkOutput("frame_ack", ack, 0);
          checkOutput("frame_rsp_valid", cmd_if.rsp_valid, 0);
          bitn++;
          if (bitn == FRAME_BITS) begin
            phase = 2;
            wcnt  = 0;
          end
        end else if (phase == 2) begin
          checkOutput("wait_data", data, 0);
          checkOutput("wait_busy", busy, 1);
          checkOutput("wait_ready", cmd_if.cmd_ready, 0);
          if (cmd_if.rsp_valid === 1'b1) begin
            checkOutput("rsp_latency", wcnt, expRspLatency(cur.done_after));
            checkOutput("rsp_timeout", cmd_if.rsp_timeout, expTimeout(cur.done_after));
            checkOutput("rsp_cycles", cmd_if.rsp_cycles, expCycles(cur.done_after));
            checkOutput("rsp_ack", ack, !expTimeout(cur.done_after));
            held_cycles = CNT_W'(expCycles(cur.done_after));
            phase = 3;
            k     = 0;
          end else begin
            checkOutput("wait_ack", ack, 0);
            wcnt++;
            if (wcnt > TIMEOUT_CYC + 8) begin
              checkOutput("rsp_missing", cmd_if.rsp_valid, 1);
              phase = 0;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus
  initial begin : stimulus
    logic [3:0] dl;
    int         dd;
    bit         hold;
    int         n;
    cmd_t       c;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_delay = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end

    $display("[TB] basic send with done after 2000 cycles");
    applyStimulus(4'b0101, 2000, 1'b0);

    $display("[TB] done already high on the first wait cycle");
    applyStimulus(4'($urandom_range(0, 15)), 0, 1'b0);

    $display("[TB] random commands");
    for (int i = 0; i < 8; i++) begin
      dl   = 4'($urandom_range(0, 15));
      dd   = int'($urandom_range(0, 1200));
      hold = ($urandom_range(0, 1) == 1);
      applyStimulus(dl, dd, hold);
      if (!hold) begin
        repeat ($urandom_range(0, 4)) begin
          @(posedge clk); #1;
        end
      end
    end

    $display("[TB] back-to-back with cmd_valid held");
    applyStimulus(4'b1010, 5, 1'b1);
    applyStimulus(4'b0011, 0, 1'b1);
    applyStimulus(4'b1000, 30, 1'b0);

    $display("[TB] timeout");
    applyStimulus(4'($urandom_range(0, 15)), TIMEOUT_CYC, 1'b0);

    $display("[TB] done on the timeout cycle");
    applyStimulus(4'($urandom_range(0, 15)), TIMEOUT_CYC - 1, 1'b0);

    $display("[TB] reset in the middle of the delay bits");
    c.delay      = 4'b1111;
    c.done_after = 0;
    exp_q.push_back(c);
    cmd_if.cmd_delay = 4'b1111;
    cmd_if.cmd_valid = 1'b1;
    n = 0;
    while (cmd_if.cmd_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("reset_test_accept", cmd_if.cmd_ready, 1);
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    checkOutput("pre_reset_data", data, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_data", data, 0);
    checkOutput("async_reset_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end

    $display("[TB] command after reset");
    applyStimulus(4'($urandom_range(0, 15)), int'($urandom_range(0, 300)), 1'b0);

    repeat (6) begin
      @(posedge clk); #1;
    end
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
